// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic detector and signal controller.
package traffic_pkg;

  localparam int DEB_DEF   = 4;
  localparam int HOLD_DEF  = 8;
  localparam int STUCK_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_HOLD,
    ST_FAULT
  } det_state_t;

  typedef enum logic [1:0] {
    LT_GREEN,
    LT_YELLOW,
    LT_RED
  } light_t;

endpackage

// File: rtl/detector_channel.sv
// One loop-detector channel: synchronizer, debouncer,
// presence FSM with hold extension and stuck-detector fault.
module detector_channel
  import traffic_pkg::*;
#(
  parameter int DEB   = DEB_DEF,
  parameter int HOLD  = HOLD_DEF,
  parameter int STUCK = STUCK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic det,
  output logic t,
  output logic fault
);

  localparam int DW = $clog2(DEB + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam int SW = $clog2(STUCK + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB - 1);
  localparam logic [DW-1:0] DEB_ONE    = DW'(1);
  localparam logic [HW-1:0] HOLD_LD    = HW'(HOLD);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK - 1);
  localparam logic [SW-1:0] STUCK_ONE  = SW'(1);

  logic [1:0]    sync;
  logic          deb;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [SW-1:0] stuck_cnt, stuck_n;
  det_state_t    state, state_n;
  logic          t_n, fault_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync <= {sync[0], det};
      if (sync[1] == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= sync[1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      stuck_cnt <= '0;
      t         <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      stuck_cnt <= stuck_n;
      t         <= t_n;
      fault     <= fault_n;
    end
  end

  // Retrigger in HOLD wins over hold expiry.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    stuck_n = stuck_cnt;
    unique case (state)
      ST_IDLE: begin
        if (deb) begin
          state_n = ST_PRESENT;
          stuck_n = '0;
        end
      end
      ST_PRESENT: begin
        if (!deb) begin
          state_n = ST_HOLD;
          hold_n  = HOLD_LD;
          stuck_n = '0;
        end else if (stuck_cnt == STUCK_LAST) begin
          state_n = ST_FAULT;
          stuck_n = '0;
        end else begin
          stuck_n = stuck_cnt + STUCK_ONE;
        end
      end
      ST_HOLD: begin
        if (deb) begin
          state_n = ST_PRESENT;
          hold_n  = '0;
        end else if (hold_cnt <= HOLD_ONE) begin
          state_n = ST_IDLE;
          hold_n  = '0;
        end else begin
          hold_n = hold_cnt - HOLD_ONE;
        end
      end
      ST_FAULT: begin
        if (!deb) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        hold_n  = '0;
        stuck_n = '0;
      end
    endcase
    t_n     = (state_n == ST_PRESENT) ||
              (state_n == ST_HOLD);
    fault_n = (state_n == ST_FAULT);
  end

endmodule

// File: rtl/traffic_detector.sv
// Two independent vehicle-presence channels feeding the
// signal controller's TA/TB inputs.
module traffic_detector
  import traffic_pkg::*;
#(
  parameter int DEB   = DEB_DEF,
  parameter int HOLD  = HOLD_DEF,
  parameter int STUCK = STUCK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic det_a,
  input  logic det_b,
  output logic TA,
  output logic TB,
  output logic fault_a,
  output logic fault_b
);

  detector_channel #(
    .DEB   (DEB),
    .HOLD  (HOLD),
    .STUCK (STUCK)
  ) u_a (
    .clk   (clk),
    .rst   (rst),
    .det   (det_a),
    .t     (TA),
    .fault (fault_a)
  );

  detector_channel #(
    .DEB   (DEB),
    .HOLD  (HOLD),
    .STUCK (STUCK)
  ) u_b (
    .clk   (clk),
    .rst   (rst),
    .det   (det_b),
    .t     (TB),
    .fault (fault_b)
  );

endmodule

// File: tb/tb_traffic_detector.sv
// Directed bench for traffic_detector at DEB=4, HOLD=8, STUCK=64.
// Edge numbers count rising edges after reset release.
module tb_traffic_detector;

  logic clk = 1'b0;
  logic rst;
  logic det_a;
  logic det_b;
  logic TA, TB, fault_a, fault_b;

  int cyc;
  int n_cmp;
  int n_bad;

  traffic_detector #(
    .DEB   (4),
    .HOLD  (8),
    .STUCK (64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .det_a   (det_a),
    .det_b   (det_b),
    .TA      (TA),
    .TB      (TB),
    .fault_a (fault_a),
    .fault_b (fault_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic got,
                     input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %b want %b",
               tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step();
  endtask

  logic seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    det_a = 1'b0;
    det_b = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    chk("rst_ta", TA, 1'b0);
    chk("rst_tb", TB, 1'b0);
    chk("rst_fa", fault_a, 1'b0);
    chk("rst_fb", fault_b, 1'b0);

    // det_a high, first sample at edge 1
    det_a = 1'b1;
    run_to(6);
    chk("a_rise_pre", TA, 1'b0);
    run_to(7);
    chk("a_rise", TA, 1'b1);
    chk("a_rise_tb", TB, 1'b0);
    chk("a_rise_fa", fault_a, 1'b0);

    // first low sample at edge 30
    run_to(29);
    det_a = 1'b0;
    run_to(43);
    chk("a_hold_end", TA, 1'b1);
    run_to(44);
    chk("a_fall", TA, 1'b0);

    // 3-cycle glitch
    run_to(50);
    det_a = 1'b1;
    run_to(53);
    det_a = 1'b0;
    seen = 1'b0;
    while (cyc < 70) begin
      step();
      if (TA !== 1'b0) seen = 1'b1;
    end
    chk("a_glitch", seen, 1'b0);

    // retrigger during HOLD: no dropout
    det_a = 1'b1;
    run_to(76);
    chk("a_rise2_pre", TA, 1'b0);
    run_to(77);
    chk("a_rise2", TA, 1'b1);
    seen = 1'b0;
    while (cyc < 130) begin
      step();
      if (cyc == 89) det_a = 1'b0;
      if (cyc == 95) det_a = 1'b1;
      if (TA !== 1'b1) seen = 1'b1;
    end
    chk("a_retrig_drop", seen, 1'b0);
    det_a = 1'b0;
    run_to(144);
    chk("a_hold2_end", TA, 1'b1);
    run_to(145);
    chk("a_fall2", TA, 1'b0);

    // street B: presence then stuck fault
    run_to(150);
    det_b = 1'b1;
    run_to(156);
    chk("b_rise_pre", TB, 1'b0);
    run_to(157);
    chk("b_rise", TB, 1'b1);
    run_to(220);
    chk("b_prefault_tb", TB, 1'b1);
    chk("b_prefault_fb", fault_b, 1'b0);
    run_to(221);
    chk("b_fault_tb", TB, 1'b0);
    chk("b_fault_fb", fault_b, 1'b1);
    chk("b_fault_fa", fault_a, 1'b0);
    chk("b_fault_ta", TA, 1'b0);
    run_to(230);
    det_b = 1'b0;
    run_to(236);
    chk("b_rel_pre", fault_b, 1'b1);
    run_to(237);
    chk("b_rel_fb", fault_b, 1'b0);
    chk("b_rel_tb", TB, 1'b0);
    run_to(238);
    chk("b_no_hold", TB, 1'b0);

    // both channels into HOLD, then reset
    run_to(240);
    det_a = 1'b1;
    det_b = 1'b1;
    run_to(247);
    chk("ab_ta", TA, 1'b1);
    chk("ab_tb", TB, 1'b1);
    run_to(259);
    det_a = 1'b0;
    det_b = 1'b0;
    run_to(269);
    chk("ab_hold_ta", TA, 1'b1);
    chk("ab_hold_tb", TB, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("hrst_ta", TA, 1'b0);
    chk("hrst_tb", TB, 1'b0);
    chk("hrst_fa", fault_a, 1'b0);
    chk("hrst_fb", fault_b, 1'b0);

    // rise after reset
    run_to(275);
    det_a = 1'b1;
    run_to(281);
    chk("post_rst_pre", TA, 1'b0);
    run_to(282);
    chk("post_rst_ta", TA, 1'b1);
    chk("post_rst_tb", TB, 1'b0);

    // reset wins over an active input
    run_to(290);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_prio_ta", TA, 1'b0);
    run_to(297);
    chk("rst_prio_pre", TA, 1'b0);
    run_to(298);
    chk("rst_prio_rise", TA, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
